// File: rtl/pio_apb_arb_if.sv
// pio_apb_arb_if: APB bus between the requester arbiter (master) and the PIO wrapper (slave).
interface pio_apb_arb_if #(
    parameter int AW = 12
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pio_apb_arb.sv
// pio_apb_arb: round-robin arbiter sequencing NREQ word requesters onto one APB master port.
// Optional ACCESS-phase timeout built only when PIO_ARB_TIMEOUT_EN is defined.
module pio_apb_arb #(
    parameter int         NREQ    = 4,
    parameter int         AW      = 12,
    parameter logic [2:0] PPROT_V = 3'b000,
    parameter int         TO_CYC  = 255
) (
    input  logic               pclk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0]  req_strb,
    output logic [NREQ-1:0]    ack,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               timeout,
    pio_apb_arb_if.master      apb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n, gnt, gnt_n, sel;
    logic          psel, psel_n, penable, penable_n, pwrite, pwrite_n;
    logic [AW-1:0] paddr, paddr_n;
    logic [31:0]   pwdata, pwdata_n, rdata_n;
    logic [3:0]    pstrb, pstrb_n;
    logic [NREQ-1:0] ack_n;
    logic          err_n, busy_n;
`ifdef PIO_ARB_TIMEOUT_EN
    localparam int TW = (TO_CYC > 255) ? 16 : 8;
    logic [TW-1:0] cnt, cnt_n;
    logic          to_n;
`else
    assign timeout = 1'b0;
`endif

    assign apb.psel    = psel;
    assign apb.penable = penable;
    assign apb.pwrite  = pwrite;
    assign apb.paddr   = paddr;
    assign apb.pwdata  = pwdata;
    assign apb.pstrb   = pstrb;
    assign apb.pprot   = PPROT_V;

    // Descending scan so the candidate closest above ptr is written last and wins.
    always_comb begin
        sel = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[PW'((int'(ptr) + i) % NREQ)]) sel = PW'((int'(ptr) + i) % NREQ);
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        psel_n    = psel;
        penable_n = penable;
        pwrite_n  = pwrite;
        paddr_n   = paddr;
        pwdata_n  = pwdata;
        pstrb_n   = pstrb;
        ack_n     = '0;
        rdata_n   = '0;
        err_n     = 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
        cnt_n     = cnt;
        to_n      = 1'b0;
`endif
        case (state)
            IDLE: if (|req) begin
                state_n  = SETUP;
                gnt_n    = sel;
                ptr_n    = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                psel_n   = 1'b1;
                pwrite_n = req_we[sel];
                paddr_n  = req_addr[sel*AW +: AW];
                pwdata_n = req_wdata[sel*32 +: 32];
                pstrb_n  = req_we[sel] ? req_strb[sel*4 +: 4] : 4'h0;
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
`ifdef PIO_ARB_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            ACCESS: if (apb.pready) begin
                state_n   = DONE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
                ack_n     = NREQ'(1) << gnt;
                rdata_n   = pwrite ? 32'h0 : apb.prdata;
                err_n     = apb.pslverr;
            end
`ifdef PIO_ARB_TIMEOUT_EN
            // This cycle is the TO_CYC-th not-ready ACCESS cycle.
            else if (cnt == TW'(TO_CYC - 1)) begin
                state_n   = DONE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
                ack_n     = NREQ'(1) << gnt;
                err_n     = 1'b1;
                to_n      = 1'b1;
            end else cnt_n = cnt + 1'b1;
`endif
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge pclk) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            ack       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
            cnt       <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt       <= gnt_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pstrb     <= pstrb_n;
            ack       <= ack_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            busy      <= busy_n;
`ifdef PIO_ARB_TIMEOUT_EN
            cnt       <= cnt_n;
            timeout   <= to_n;
`endif
        end
    end
endmodule

// File: tb/tb_pio_apb_arb.sv
// tb_pio_apb_arb: directed stimulus with an ack scoreboard for pio_apb_arb.
// Exercises the PIO_ARB_TIMEOUT_EN branch when that macro is defined.
module tb_pio_apb_arb;
    localparam int NREQ = 4;
    localparam int AW = 12;
    localparam int TO = 8;
    localparam logic [2:0] PPV = 3'b010;

    logic pclk = 1'b0;
    logic resetn = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_we = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ*4-1:0] req_strb = '0;
    logic [NREQ-1:0] ack;
    logic [31:0] rsp_rdata;
    logic rsp_err, busy, timeout;

    pio_apb_arb_if #(.AW(AW)) bus();

    pio_apb_arb #(.NREQ(NREQ), .AW(AW), .PPROT_V(PPV), .TO_CYC(TO)) dut (
        .pclk(pclk), .resetn(resetn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .ack(ack), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .timeout(timeout), .apb(bus)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [31:0]     rdata;
        logic            err;
        logic            tmo;
        int              at;
    } exp_t;
    exp_t sbq[$];

    int ws = 0;
    bit stuck = 0;
    bit err_val = 0;
    logic [31:0] rd_val = '0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_req(int i, bit we, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4] = s;
    endtask

    task automatic push(logic [NREQ-1:0] a, logic [31:0] d, bit er, bit tmo, int at);
        sbq.push_back('{ack: a, rdata: d, err: er, tmo: tmo, at: at});
    endtask

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    // APB slave: pready after ws wait states of ACCESS, never while stuck.
    int wcnt = 0;
    initial forever begin
        @(negedge pclk);
        if (bus.psel && bus.penable) begin
            bus.pready = !stuck && (wcnt == ws);
            wcnt++;
        end else begin
            bus.pready = 1'b0;
            wcnt = 0;
        end
        bus.prdata = rd_val;
        bus.pslverr = err_val;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack got=%b required=none cyc=%0d", ack, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_vec", 32'(ack), 32'(e.ack));
                    chk("ack_cycle", cyc, e.at);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("timeout", 32'(timeout), 32'(e.tmo));
                end
            end else if (timeout) begin
                tests++;
                fails++;
                $display("FAIL stray_timeout got=1 required=0 cyc=%0d", cyc);
            end
        end
    end

    initial begin
        int k;
        logic [AW-1:0] a;
        int g;
        tick(3);
        chk("rst_psel", 32'(bus.psel), 0);
        chk("rst_penable", 32'(bus.penable), 0);
        chk("rst_payload", {bus.paddr, bus.pstrb, bus.pwrite}, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pprot", 32'(bus.pprot), 32'(PPV));
        chk("rst_ack_rsp", {ack, rsp_err, busy, timeout}, 0);
        chk("rst_rdata", rsp_rdata, 0);

        // single write
        set_req(0, 1, 12'h0C8, 32'hDEADBEEF, 4'hF);
        resetn = 1'b1;
        req = 4'b0001;
        k = cyc;
        push(4'b0001, 32'h0, 0, 0, k + 3);
        tick(1);
        chk("t1_setup_ctl", {bus.psel, bus.penable, bus.pwrite, busy}, 32'b1011);
        chk("t1_paddr", 32'(bus.paddr), 32'h0C8);
        chk("t1_pwdata", bus.pwdata, 32'hDEADBEEF);
        chk("t1_pstrb", 32'(bus.pstrb), 32'hF);
        tick(1);
        chk("t1_access_ctl", {bus.psel, bus.penable}, 32'b11);
        tick(1);
        req = 4'b0000;
        chk("t1_done_psel", {bus.psel, bus.penable}, 0);
        tick(1);
        chk("t1_idle_busy", 32'(busy), 0);

        // read with 3 wait states
        ws = 3;
        rd_val = 32'h12345678;
        set_req(2, 0, 12'h004, 32'h0, 4'hF);
        req = 4'b0100;
        k = cyc;
        push(4'b0100, 32'h12345678, 0, 0, k + 6);
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("t2_pstrb", 32'(bus.pstrb), 0);
            chk("t2_pwrite", 32'(bus.pwrite), 0);
        end
        tick(1);
        req = 4'b0000;
        tick(1);

        // all four requesters held from reset
        ws = 0;
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1, AW'(12'h100 + i * 16), 32'hA0000000 + i, 4'h3);
        req = 4'b1111;
        tick(2);
        resetn = 1'b1;
        k = cyc;
        for (int n = 0; n < 5; n++) push(NREQ'(1) << (n % NREQ), 32'h0, 0, 0, k + 3 + 4 * n);
        for (int n = 0; n < 5; n++) begin
            g = n % NREQ;
            a = AW'(12'h100 + g * 16);
            tick(1);
            chk("t3_setup_paddr", 32'(bus.paddr), 32'(a));
            chk("t3_setup_pwdata", bus.pwdata, 32'hA0000000 + g);
            tick(1);
            chk("t3_access_paddr", 32'(bus.paddr), 32'(a));
            chk("t3_access_pwdata", bus.pwdata, 32'hA0000000 + g);
            tick(1);
            if (n == 4) req = 4'b0000;
            tick(1);
        end

        // PSLVERR on req[1]; pointer then favours req[2] over pending req[0]
        set_req(0, 1, 12'h0F0, 32'h11111111, 4'hF);
        set_req(1, 1, 12'h0A0, 32'h22222222, 4'hC);
        set_req(2, 0, 12'h004, 32'h0, 4'hF);
        err_val = 1;
        rd_val = 32'hCAFEF00D;
        req = 4'b0111;
        k = cyc;
        push(4'b0010, 32'h0, 1, 0, k + 3);
        push(4'b0100, 32'hCAFEF00D, 0, 0, k + 7);
        push(4'b0001, 32'h0, 0, 0, k + 11);
        tick(1);
        chk("t4_first_paddr", 32'(bus.paddr), 32'h0A0);
        tick(2);
        req = 4'b0101;
        err_val = 0;
        tick(2);
        chk("t4_second_paddr", 32'(bus.paddr), 32'h004);
        tick(2);
        req = 4'b0001;
        tick(4);
        req = 4'b0000;
        tick(1);

        // reset during ACCESS, then req[3] and req[0] pending
        ws = 5;
        set_req(0, 1, 12'h0C0, 32'h55AA55AA, 4'hF);
        set_req(3, 1, 12'h3C0, 32'h33333333, 4'hF);
        req = 4'b0001;
        tick(2);
        chk("t5_in_access", {bus.psel, bus.penable}, 32'b11);
        resetn = 1'b0;
        req = 4'b1001;
        ws = 0;
        tick(1);
        chk("t5_rst_ctl", {bus.psel, bus.penable, busy}, 0);
        chk("t5_rst_ack", 32'(ack), 0);
        resetn = 1'b1;
        k = cyc;
        push(4'b0001, 32'h0, 0, 0, k + 3);
        push(4'b1000, 32'h0, 0, 0, k + 7);
        tick(1);
        chk("t5_first_paddr", 32'(bus.paddr), 32'h0C0);
        tick(2);
        req = 4'b1000;
        tick(4);
        req = 4'b0000;
        tick(1);

        // PREADY stuck low
        stuck = 1;
        rd_val = 32'hDEADC0DE;
        set_req(1, 0, 12'h010, 32'h0, 4'hF);
        req = 4'b0010;
        k = cyc;
`ifdef PIO_ARB_TIMEOUT_EN
        push(4'b0010, 32'h0, 1, 1, k + 2 + TO);
        tick(1 + TO);
        chk("t6_pre_timeout", {bus.psel, bus.penable}, 32'b11);
        tick(1);
        req = 4'b0000;
        stuck = 0;
        chk("t6_dropped", {bus.psel, bus.penable}, 0);
        tick(2);
`else
        tick(1000);
        chk("t6_still_waiting", {bus.psel, bus.penable, busy}, 32'b111);
        resetn = 1'b0;
        req = 4'b0000;
        stuck = 0;
        tick(2);
        resetn = 1'b1;
        tick(2);
`endif
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
